nios_system_pio_in_irq: RTL and testbench

- Avalon-MM slave input PIO: the read-side counterpart to the system's output PIOs.
- Samples an external WIDTH-bit input bus through a synchroniser and detects configurable edges per bit.
- Latches detected edges in a write-1-to-clear capture register and raises a maskable level interrupt to the Nios II processor.
- Sits on the Avalon-MM data master interconnect next to the output PIOs; in_port connects to board switches/keys.

---
 rtl/nios_system_pio_in_irq.sv | 103 ++++++++++
 tb/tb_nios_system_pio_in_irq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_pio_in_irq.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture with
// write-1-to-clear, maskable level interrupt.
module nios_system_pio_in_irq #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CNT_W-1:0] warm_cnt;
    logic             warm_done;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] edge_capture_next;
    logic [WIDTH-1:0] irq_mask_next;
    logic             wr_en;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_MAX);
    assign wr_en     = chipselect & ~write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_in;
        end
    end

    // Warm-up masks the 0->level transition the chain shows after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync_in & ~prev;
            1:       edge_raw = ~sync_in & prev;
            default: edge_raw = sync_in ^ prev;
        endcase
        edge_det = warm_done ? edge_raw : '0;
    end

    // Set is OR-ed in after the clear so a coincident edge is never lost.
    always_comb begin
        clr_bits          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edge_capture_next = (edge_capture & ~clr_bits) | edge_det;
        irq_mask_next     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= edge_capture_next;
            irq_mask     <= irq_mask_next;
            irq          <= |(edge_capture_next & irq_mask_next);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = sync_in;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Directed bench for nios_system_pio_in_irq: rising (main), falling and
// any-edge instances share the bus and inputs.
module tb_nios_system_pio_in_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_port;
    logic [31:0] readdata_r, readdata_f, readdata_a;
    logic        irq_r, irq_f, irq_a;

    int checks = 0;
    int errors = 0;

    nios_system_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_r), .irq(irq_r)
    );

    nios_system_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_f), .irq(irq_f)
    );

    nios_system_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_a), .irq(irq_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] r,
                            output logic [31:0] f, output logic [31:0] x);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        r = readdata_r; f = readdata_f; x = readdata_a;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r, f, x;
        reset = 1'b1; in_port = 3'b111;
        wait_cycles(3);
        checks++;
        if (irq_r !== 1'b0 || readdata_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: irq=%b readdata=%h expected irq=0 readdata=0", irq_r, readdata_r);
        end
        reset = 1'b0;
        wait_cycles(10);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h0 || f !== 32'h0 || x !== 32'h0) begin
            errors++;
            $display("FAIL warmup_capture: rise=%h fall=%h any=%h expected 0", r, f, x);
        end
        checks++;
        if (irq_r !== 1'b0 || irq_f !== 1'b0 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL warmup_irq: irq=%b%b%b expected 000", irq_r, irq_f, irq_a);
        end
        bus_read(2'd0, r, f, x);
        checks++;
        if (r !== 32'h7) begin
            errors++;
            $display("FAIL warmup_data: got %h expected 00000007", r);
        end
        bus_read(2'd1, r, f, x);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read: got %h expected 0", r);
        end
    endtask

    task automatic test_rising;
        logic [31:0] r, f, x;
        in_port = 3'b000;
        wait_cycles(4);
        bus_write(2'd2, 32'h7);
        bus_write(2'd3, 32'h7);
        in_port = 3'b010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (irq_r !== 1'b0) begin
                errors++;
                $display("FAIL rise_latency_%0d: irq=%b expected 0", i, irq_r);
            end
        end
        @(negedge clk);
        checks++;
        if (irq_r !== 1'b1) begin
            errors++;
            $display("FAIL rise_irq: irq=%b expected 1", irq_r);
        end
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h2) begin
            errors++;
            $display("FAIL rise_capture: got %h expected 00000002", r);
        end
        bus_read(2'd2, r, f, x);
        checks++;
        if (r !== 32'h7) begin
            errors++;
            $display("FAIL mask_read: got %h expected 00000007", r);
        end
    endtask

    task automatic test_clear_mask;
        logic [31:0] r, f, x;
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h0 || irq_r !== 1'b0) begin
            errors++;
            $display("FAIL clear: capture=%h irq=%b expected 0 0", r, irq_r);
        end
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'h7);
        bus_write(2'd1, 32'h7);
        bus_read(2'd2, r, f, x);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL ignored_write: mask=%h expected 00000001", r);
        end
        in_port = 3'b000;
        wait_cycles(4);
        in_port = 3'b010;
        wait_cycles(4);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h2 || irq_r !== 1'b0) begin
            errors++;
            $display("FAIL masked_edge: capture=%h irq=%b expected 2 0", r, irq_r);
        end
        bus_write(2'd2, 32'h3);
        checks++;
        if (irq_r !== 1'b1) begin
            errors++;
            $display("FAIL unmask_irq: irq=%b expected 1", irq_r);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] r, f, x;
        in_port = 3'b011;
        wait_cycles(2);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h3 || irq_r !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: capture=%h irq=%b expected 3 1", r, irq_r);
        end
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h2) begin
            errors++;
            $display("FAIL plain_clear: capture=%h expected 00000002", r);
        end
    endtask

    task automatic test_edge_types;
        logic [31:0] r, f, x;
        in_port = 3'b111;
        wait_cycles(4);
        bus_write(2'd3, 32'h7);
        in_port = 3'b011;
        wait_cycles(4);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h0 || f !== 32'h4 || x !== 32'h4) begin
            errors++;
            $display("FAIL fall_edge: rise=%h fall=%h any=%h expected 0 4 4", r, f, x);
        end
        bus_write(2'd3, 32'h7);
        in_port = 3'b111;
        wait_cycles(4);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h4 || f !== 32'h0 || x !== 32'h4) begin
            errors++;
            $display("FAIL rise_edge: rise=%h fall=%h any=%h expected 4 0 4", r, f, x);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] r, f, x;
        in_port = 3'b000;
        wait_cycles(4);
        bus_write(2'd2, 32'h7);
        bus_write(2'd3, 32'h7);
        in_port = 3'b101;
        wait_cycles(4);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h5 || irq_r !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: capture=%h irq=%b expected 5 1", r, irq_r);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h0 || irq_r !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: capture=%h irq=%b expected 0 0", r, irq_r);
        end
        bus_read(2'd2, r, f, x);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL async_mask: got %h expected 0", r);
        end
        bus_read(2'd0, r, f, x);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL async_data: got %h expected 0", r);
        end
        #1 reset = 1'b0;
        wait_cycles(10);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h0 || x !== 32'h0) begin
            errors++;
            $display("FAIL rewarm_capture: rise=%h any=%h expected 0 0", r, x);
        end
        bus_read(2'd0, r, f, x);
        checks++;
        if (r !== 32'h5) begin
            errors++;
            $display("FAIL rewarm_data: got %h expected 00000005", r);
        end
        bus_write(2'd2, 32'h7);
        in_port = 3'b000;
        wait_cycles(4);
        in_port = 3'b101;
        wait_cycles(4);
        bus_read(2'd3, r, f, x);
        checks++;
        if (r !== 32'h5 || irq_r !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_capture: capture=%h irq=%b expected 5 1", r, irq_r);
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        @(negedge clk);
        test_reset;
        test_rising;
        test_clear_mask;
        test_simultaneous;
        test_edge_types;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
